// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM states and constants for hazard_controller and its helpers
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  localparam int MEM_TIMEOUT_DEF = 16;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_sat_counter.sv
// hazard_sat_counter: CNT_W-bit saturating up-counter; ports clk, rst (sync clear), inc (enable), count
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    count <= rst ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use/branch/mem-wait hazard control with timeout trap; in: clk rst id_ex_mem_read id_ex_rt if_id_rs if_id_rt if_id_uses_rt branch_taken mem_req mem_ack; out: freeze IF_Flush id_ex_bubble pipe_hold mem_timeout stall_cycles flush_count (counters live only with HAZARD_PERF_CNT_EN)
module hazard_controller import hazard_pkg::*; #(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             freeze,
  output logic             IF_Flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  state_t state;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic lu;
  assign lu = id_ex_mem_read && id_ex_rt != REG_ZERO &&
              (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
  assign wait_nxt = wait_cnt + 1'b1;
  assign pipe_hold = !rst && (state == ERROR ||
                     (!mem_ack && (state == MEM_WAIT || (state == RUN && mem_req))));
  assign freeze = pipe_hold || (!rst && lu);
  assign id_ex_bubble = !rst && !pipe_hold && lu;
  assign IF_Flush = !rst && !pipe_hold && !lu && branch_taken;
  assign mem_timeout = !rst && state == ERROR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
    end else if (state == RUN && mem_req && !mem_ack) begin
      state <= MEM_WAIT;
      wait_cnt <= CNT_W'(1);
    end else if (state == MEM_WAIT && mem_ack) begin
      state <= RUN;
      wait_cnt <= '0;
    end else if (state == MEM_WAIT) begin
      state <= wait_nxt >= CNT_W'(MEM_TIMEOUT) ? ERROR : MEM_WAIT;
      wait_cnt <= wait_nxt;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] st_q, fl_q;
  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(freeze), .count(st_q));
  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(IF_Flush), .count(fl_q));
  assign stall_cycles = rst ? '0 : st_q;
  assign flush_count = rst ? '0 : fl_q;
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench for hazard_controller against a cycle-level reference model
module tb_hazard_controller;
  localparam int TO = 4;
  typedef struct {
    logic fz, fl, bb, ph, tm;
    logic [31:0] st, fc;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic id_ex_mem_read = 0, if_id_uses_rt = 0, branch_taken = 0, mem_req = 0, mem_ack = 0;
  logic [4:0] id_ex_rt = 0, if_id_rs = 0, if_id_rt = 0;
  logic freeze, IF_Flush, id_ex_bubble, pipe_hold, mem_timeout;
  logic [31:0] stall_cycles, flush_count;
  exp_t q[$];
  int tests = 0, fails = 0, cyc_n = 0;
  bit m_err = 0;
  int m_wait = 0;
  longint m_st = 0, m_fl = 0;
  always #5 clk = ~clk;
  hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .freeze(freeze), .IF_Flush(IF_Flush), .id_ex_bubble(id_ex_bubble),
    .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc_n, a, e);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      cyc_n++;
      chk("freeze", 32'(freeze), 32'(e.fz));
      chk("IF_Flush", 32'(IF_Flush), 32'(e.fl));
      chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bb));
      chk("pipe_hold", 32'(pipe_hold), 32'(e.ph));
      chk("mem_timeout", 32'(mem_timeout), 32'(e.tm));
      chk("stall_cycles", stall_cycles, e.st);
      chk("flush_count", flush_count, e.fc);
    end
  end
  task automatic cyc(bit r, bit mr, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt,
                     bit urt, bit br, bit mq, bit ma);
    exp_t e;
    bit lu;
    rst = r; id_ex_mem_read = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
    if_id_uses_rt = urt; branch_taken = br; mem_req = mq; mem_ack = ma;
    e = '{default: '0};
    if (r) begin
      m_err = 0; m_wait = 0; m_st = 0; m_fl = 0;
    end else begin
      lu = mr && ert != 0 && (ert == rs || (urt && ert == rt));
`ifdef HAZARD_PERF_CNT_EN
      e.st = m_st[31:0];
      e.fc = m_fl[31:0];
`endif
      if (m_err) begin
        e.ph = 1; e.fz = 1; e.tm = 1;
      end else if (!ma && (mq || m_wait > 0)) begin
        e.ph = 1; e.fz = 1;
        m_wait++;
        if (m_wait >= TO) m_err = 1;
      end else begin
        m_wait = 0;
        e.fz = lu; e.bb = lu; e.fl = !lu && br;
      end
      if (e.fz && m_st < 64'hFFFF_FFFF) m_st++;
      if (e.fl && m_fl < 64'hFFFF_FFFF) m_fl++;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 5, 5, 1, 1, 1, 0);
    cyc(0, 1, 5, 5, 0, 0, 0, 0, 0);
    cyc(0, 0, 5, 5, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 7, 1, 7, 0, 0, 0, 0);
    cyc(0, 1, 7, 1, 7, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 3, 3, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 4, 4, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 2, 2, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, i[0], 1, 0);
    cyc(1, 1, 5, 5, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 59) == 0, 1'($urandom), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and hold controller for the 5-stage MIPS pipeline. It drives the `freeze` and `IF_Flush` inputs of the IF/ID register, the bubble-insert control of the ID/EX register, and a global hold for the later stage registers. It covers load-use stalls, taken-branch flushes and multi-cycle data-memory waits, including a timeout watchdog.

## Interface
- `MEM_TIMEOUT`, 16: maximum consecutive memory-wait cycles before the error trap.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_ex_mem_read`  in  1  the instruction in EX is a load.
- `id_ex_rt`  in  5  load destination register.
- `if_id_rs`  in  5  source register rs of the instruction in ID.
- `if_id_rt`  in  5  source register rt of the instruction in ID.
- `if_id_uses_rt`  in  1  the ID instruction reads rt (R-type, store, beq/bne).
- `branch_taken`  in  1  branch/jump resolved taken in ID this cycle.
- `mem_req`  in  1  MEM stage holds a load or store.
- `mem_ack`  in  1  data memory completes the access this cycle.
- `freeze`  out  1  hold PC and IF/ID.
- `IF_Flush`  out  1  zero the IF/ID instruction.
- `id_ex_bubble`  out  1  load zero controls into ID/EX.
- `pipe_hold`  out  1  hold ID/EX, EX/MEM and MEM/WB.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cycles`  out  CNT_W  count of cycles with `freeze`=1.
- `flush_count`  out  CNT_W  count of cycles with `IF_Flush`=1.

## Operation
- States: RUN, MEM_WAIT, ERROR. A wait counter tracks consecutive memory-wait cycles.
- Load-use hazard (lu) is asserted when all of the following hold:
  - `id_ex_mem_read` is 1.
  - `id_ex_rt` is not 0.
  - `id_ex_rt` equals `if_id_rs`, or `if_id_uses_rt` is 1 and `id_ex_rt` equals `if_id_rt`.
- RUN, evaluated in priority order:
  - `mem_req` and not `mem_ack`: `pipe_hold`=1 and `freeze`=1. Next state MEM_WAIT, counter set to 1.
  - Otherwise lu: `freeze`=1 and `id_ex_bubble`=1.
  - Otherwise `branch_taken`: `IF_Flush`=1.
  - Otherwise all control outputs are 0.
- MEM_WAIT:
  - `mem_ack`=0: `pipe_hold`=1 and `freeze`=1; the counter increments. When the counter reaches MEM_TIMEOUT, next state is ERROR.
  - `mem_ack`=1: `pipe_hold`=0 this cycle. Next state RUN, counter cleared. lu and flush are evaluated as in RUN during this cycle.
- ERROR: `pipe_hold`=1, `freeze`=1 and `mem_timeout`=1. The block stays in ERROR until `rst`.
- While `pipe_hold`=1, `id_ex_bubble` and `IF_Flush` are forced to 0. The whole pipe is frozen, so no bubble or flush is issued.
- lu together with `branch_taken` in the same cycle: the stall wins and the flush is suppressed. The branch is re-resolved when the instruction next occupies ID.
- The counter is CNT_W bits and has no wrap.

## Timing
- Control outputs are Mealy functions of the registered state and the current inputs, with zero-cycle latency. This is required so the pipeline registers see them before the same clock edge.
- A zero-wait access (`mem_req` and `mem_ack` in the same cycle) produces no hold.
- An N-cycle memory wait holds for exactly N cycles, ending in the `mem_ack` cycle with hold 0.
- A load-use stall lasts one cycle. The next cycle the load is in MEM and lu drops naturally.
- Reset:
  - While `rst`=1, every output is 0.
  - On the next edge: state RUN, counter 0, `mem_timeout` 0, perf counters 0.
  - Reset during MEM_WAIT or ERROR returns to RUN with no residual hold.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cycles` and `flush_count` increment on each cycle where `freeze` (respectively `IF_Flush`) is 1, and saturate at all-ones.
- Macro undefined: the counters are not instantiated and both ports are tied to 0. Control behaviour is identical in both builds.

## Structure
- Package `hazard_pkg`:
  - state enum (RUN, MEM_WAIT, ERROR).
  - MEM_TIMEOUT default.
  - REG_ZERO constant (5'd0).
- Sub-module `hazard_sat_counter`: CNT_W-wide saturating counter with synchronous clear and increment enable. It is instantiated twice under the macro.

## Test plan
- Load r5 in EX, ID reads rs=5 → `freeze`=1 and `id_ex_bubble`=1 for one cycle; `IF_Flush`=0.
- Load r0 in EX, ID reads rs=0 → no stall.
- Load r7 in EX, ID rt=7 with `if_id_uses_rt`=0 → no stall.
- `branch_taken`=1 with no hazard → `IF_Flush`=1 for one cycle.
- `branch_taken` together with lu → `IF_Flush`=0 and `freeze`=1.
- `mem_req`=1, `mem_ack` arriving after 3 cycles → `pipe_hold`=1 for 3 cycles and 0 in the ack cycle.
- Same case with `HAZARD_PERF_CNT_EN` defined → `stall_cycles`=3.
- `mem_req` held with no ack, MEM_TIMEOUT=4:
  - `mem_timeout` rises after the 4th wait cycle and stays 1.
  - Asserting `rst` clears it, with all outputs 0 while `rst`=1.
